// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: interrupt entry / RTI pipeline sequencer (drain, stack push/pop, vector/restore).
// Optional IE mask bit and ie_out port when INT_MASK_EN is defined.
module int_seq_ctrl #(
   parameter int PC_W         = 32,
   parameter int DRAIN_CYCLES = 3,
   parameter int FLAG_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              int_req,
   input  logic [1:0]        int_index,
   input  logic              rti_dec,
   input  logic              mem_ready,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic [15:0]       stack_rdata,
   output logic              enable_buf,
   output logic              flush,
   output logic              stk_we,
   output logic              stk_re,
   output logic [15:0]       stk_wdata,
   output logic [1:0]        pc_select,
   output logic [1:0]        ivt_index,
   output logic [PC_W-1:0]   pc_restore,
   output logic [FLAG_W-1:0] flags_restore,
   output logic              flags_load,
   output logic              busy
`ifdef INT_MASK_EN
   ,
   output logic              ie_out
`endif
);
   typedef enum logic [3:0] {
      IDLE, DRAIN, PUSH_LO, PUSH_HI, PUSH_FLG, VECTOR,
      RTI_FLUSH, POP_FLG, POP_HI, POP_LO, RESUME
   } state_t;
   localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
   state_t state, state_nxt;
   logic pending, take, ie;
   logic [CW-1:0] cnt;
   logic [PC_W-1:0] saved_pc;
   logic [FLAG_W-1:0] saved_flags;
   assign busy = state != IDLE;
   always_comb begin
      state_nxt  = state;
      take       = 1'b0;
      enable_buf = 1'b1;
      flush      = 1'b0;
      stk_we     = 1'b0;
      stk_re     = 1'b0;
      stk_wdata  = '0;
      pc_select  = 2'b00;
      flags_load = 1'b0;
      case (state)
         IDLE: begin
            take      = !rti_dec && pending && ie;
            state_nxt = rti_dec ? RTI_FLUSH : take ? DRAIN : IDLE;
         end
         DRAIN: begin
            flush     = 1'b1;
            state_nxt = cnt == CW'(DRAIN_CYCLES - 1) ? PUSH_LO : DRAIN;
         end
         PUSH_LO: begin
            enable_buf = 1'b0;
            stk_we     = 1'b1;
            stk_wdata  = saved_pc[15:0];
            state_nxt  = mem_ready ? PUSH_HI : PUSH_LO;
         end
         PUSH_HI: begin
            enable_buf = 1'b0;
            stk_we     = 1'b1;
            stk_wdata  = saved_pc[31:16];
            state_nxt  = mem_ready ? PUSH_FLG : PUSH_HI;
         end
         PUSH_FLG: begin
            enable_buf = 1'b0;
            stk_we     = 1'b1;
            stk_wdata  = 16'(saved_flags);
            state_nxt  = mem_ready ? VECTOR : PUSH_FLG;
         end
         VECTOR: begin
            flush     = 1'b1;
            pc_select = 2'b01;
            state_nxt = IDLE;
         end
         RTI_FLUSH: begin
            flush     = 1'b1;
            state_nxt = POP_FLG;
         end
         POP_FLG: begin
            enable_buf = 1'b0;
            stk_re     = 1'b1;
            state_nxt  = mem_ready ? POP_HI : POP_FLG;
         end
         POP_HI: begin
            enable_buf = 1'b0;
            stk_re     = 1'b1;
            state_nxt  = mem_ready ? POP_LO : POP_HI;
         end
         POP_LO: begin
            enable_buf = 1'b0;
            stk_re     = 1'b1;
            state_nxt  = mem_ready ? RESUME : POP_LO;
         end
         RESUME: begin
            flush      = 1'b1;
            pc_select  = 2'b10;
            flags_load = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         pending       <= 1'b0;
         cnt           <= '0;
         saved_pc      <= '0;
         saved_flags   <= '0;
         ivt_index     <= '0;
         pc_restore    <= '0;
         flags_restore <= '0;
      end else begin
         state   <= state_nxt;
         pending <= take ? 1'b0 : pending | int_req;
         cnt     <= (state == DRAIN && state_nxt == DRAIN) ? cnt + CW'(1) : '0;
         if (take) begin
            saved_pc    <= pc_in;
            saved_flags <= flags_in;
            ivt_index   <= int_index;
         end
         if (mem_ready && state == POP_FLG) flags_restore <= stack_rdata[FLAG_W-1:0];
         if (mem_ready && state == POP_HI) pc_restore[31:16] <= stack_rdata;
         if (mem_ready && state == POP_LO) pc_restore[15:0] <= stack_rdata;
      end
`ifdef INT_MASK_EN
   // IE drops on vectoring into the ISR and comes back when RTI resumes
   always_ff @(posedge clk or posedge rst)
      if (rst) ie <= 1'b1;
      else if (state == VECTOR) ie <= 1'b0;
      else if (state == RESUME) ie <= 1'b1;
   assign ie_out = ie;
`else
   assign ie = 1'b1;
`endif
endmodule
